mul_modular_unit: RTL

- Bit-serial interleaved modular multiplier for the ECC accelerator datapath: computes (A * B) mod P over WIDTH-bit operands.
- Sits directly downstream of the modular subtraction stage. It consumes reduced differences such as (y2 - y1) and (x2 - x1) and produces the products used in slope and coordinate computation.
- Uses the same start/finish handshake style as the add/sub units.
- Multi-cycle: processes one multiplier bit per clock, MSB first.

---
 rtl/mul_modular_unit.sv | 112 +++++++++++
 1 files changed

// File: rtl/mul_modular_unit.sv
// Bit-serial interleaved modular multiplier: computes (a * b) mod p, one multiplier bit per
// clock, MSB first, with the start/finish handshake shared by the add/sub units.
module mul_modular_unit #(
  parameter int unsigned WIDTH = 64
) (
  input  logic             clk_i,
  input  logic             rst_ni,
  input  logic [WIDTH-1:0] a_i,
  input  logic [WIDTH-1:0] b_i,
  input  logic [WIDTH-1:0] p_i,
  input  logic             mul_start_i,
  output logic             mul_busy_o,
  output logic             mul_finish_o,
  output logic [WIDTH-1:0] mul_result_o
);

  localparam int unsigned CntW = (WIDTH > 1) ? $clog2(WIDTH) : 1;
  localparam int unsigned AccW = WIDTH + 2;

  typedef enum logic [1:0] {StIdle, StRun, StDone} state_e;

  state_e            state_q, state_d;
  logic [WIDTH-1:0]  a_q, a_d;
  logic [WIDTH-1:0]  b_q, b_d;
  logic [WIDTH-1:0]  p_q, p_d;
  logic [WIDTH-1:0]  res_q, res_d;
  logic [AccW-1:0]   r_q, r_d;
  logic [CntW-1:0]   cnt_q, cnt_d;

  logic [AccW-1:0]   p_ext, a_ext;
  logic [AccW-1:0]   t1, t2, t3, t4;
  logic              p_small;

  // One interleaved step: double, reduce, conditionally add a, reduce again.
  // Since r_q < p_q, every intermediate stays below 2*p and fits in WIDTH+2 bits.
  always_comb begin
    p_ext   = {2'b00, p_q};
    a_ext   = {2'b00, a_q};
    t1      = {r_q[AccW-2:0], 1'b0};
    t2      = (t1 >= p_ext) ? (t1 - p_ext) : t1;
    t3      = b_q[cnt_q] ? (t2 + a_ext) : t2;
    t4      = (t3 >= p_ext) ? (t3 - p_ext) : t3;
    p_small = (p_q[WIDTH-1:1] == '0);
  end

  always_comb begin
    state_d      = state_q;
    a_d          = a_q;
    b_d          = b_q;
    p_d          = p_q;
    r_d          = r_q;
    cnt_d        = cnt_q;
    res_d        = res_q;
    mul_busy_o   = 1'b0;
    mul_finish_o = 1'b0;

    unique case (state_q)
      StIdle: begin
        if (mul_start_i) begin
          a_d     = a_i;
          b_d     = b_i;
          p_d     = p_i;
          r_d     = '0;
          cnt_d   = CntW'(WIDTH - 1);
          state_d = StRun;
        end
      end
      StRun: begin
        mul_busy_o = 1'b1;
        r_d        = t4;
        if (cnt_q == '0) begin
          state_d = StDone;
          // A modulus below 2 has no meaningful residue; report zero instead.
          res_d   = p_small ? '0 : t4[WIDTH-1:0];
        end else begin
          cnt_d = cnt_q - CntW'(1);
        end
      end
      StDone: begin
        mul_busy_o   = 1'b1;
        mul_finish_o = 1'b1;
        state_d      = StIdle;
      end
      default: begin
        state_d = StIdle;
      end
    endcase
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q <= StIdle;
      a_q     <= '0;
      b_q     <= '0;
      p_q     <= '0;
      r_q     <= '0;
      cnt_q   <= '0;
      res_q   <= '0;
    end else begin
      state_q <= state_d;
      a_q     <= a_d;
      b_q     <= b_d;
      p_q     <= p_d;
      r_q     <= r_d;
      cnt_q   <= cnt_d;
      res_q   <= res_d;
    end
  end

  assign mul_result_o = res_q;

endmodule
